// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: reset level, access sizes,
// FSM states and the size-to-byte-count decode.
package mem_arbiter_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam int   INST_ADDR_W = 32;
    localparam int   RAM_W       = 8;
    localparam int   WORD_W      = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_RD  = 2'd1,
        ARB_MEM_RD = 2'd2,
        ARB_MEM_WR = 2'd3
    } arb_state_e;

    // Size code 3 is not a legal encoding and is served as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// MEM stage, splitting 1/2/4-byte accesses into little-endian byte transfers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int RAM_DW = RAM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [WORD_W-1:0] if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [WORD_W-1:0] mem_wdata_i,
    output logic [WORD_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [RAM_DW-1:0] ram_dout_o,
    input  logic [RAM_DW-1:0] ram_din_i
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [RAM_DW-1:0] ram_dout_q, ram_dout_d;
    logic [WORD_W-1:0] if_data_q, if_data_d;
    logic              if_done_q, if_done_d;
    logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic [1:0]        lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_data_q   <= '0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            if_done_q   <= if_done_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // cnt_q = k means the bus is in the cycle after the k-th edge since grant;
    // read byte k-1 arrives on ram_din_i during that cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        if_done_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        lane        = '0;

        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (mem_req_i) begin
                    n_d        = size_bytes(mem_size_i);
                    wdata_d    = mem_wdata_i;
                    asm_d      = '0;
                    ram_addr_d = mem_addr_i;
                    if (mem_we_i) begin
                        state_d    = ARB_MEM_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata_i[RAM_DW-1:0];
                    end else begin
                        state_d = ARB_MEM_RD;
                    end
                end else if (if_req_i && !if_flush_i) begin
                    state_d    = ARB_IF_RD;
                    n_d        = 3'd4;
                    asm_d      = '0;
                    ram_addr_d = if_addr_i;
                end
            end

            ARB_IF_RD, ARB_MEM_RD: begin
                if (state_q == ARB_IF_RD && if_flush_i) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        lane = cnt_q[1:0] - 2'd1;
                        asm_d[lane*RAM_DW +: RAM_DW] = ram_din_i;
                    end
                    if (cnt_q + 3'd1 < n_q)
                        ram_addr_d = ram_addr_q + ADDR_ONE;
                    if (cnt_q == n_q) begin
                        state_d = ARB_IDLE;
                        cnt_d   = '0;
                        if (state_q == ARB_IF_RD) begin
                            if_data_d = asm_d;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = asm_d;
                            mem_done_d  = 1'b1;
                        end
                    end
                end
            end

            ARB_MEM_WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q + 3'd1 < n_q) begin
                    lane       = cnt_q[1:0] + 2'd1;
                    ram_addr_d = ram_addr_q + ADDR_ONE;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[lane*RAM_DW +: RAM_DW];
                end else begin
                    state_d    = ARB_IDLE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    assign if_data_o   = if_data_q;
    assign if_done_o   = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte RAM behind the port, a byte-array memory model,
// directed scenarios and randomized fetch/load/store/flush traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl [logic [31:0]];

    mem_arbiter #(.ADDR_W(32), .RAM_DW(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : dflt(a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = mdl_rd(a + 32'(i));
        return r;
    endfunction

    // Synchronous byte RAM: read data appears one cycle after its address.
    always @(posedge clk) begin
        ram_din_i <= ram_rd(ram_addr_o);
        if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ram[a + 32'(i)] = w[8*i +: 8];
            mdl[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    // One access from an idle arbiter; inputs scrambled after grant to prove latching.
    task automatic xact(input bit is_if, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int n, cyc, nw, stray;
        bit done, wr;
        logic [31:0] exp, sh;
        n   = is_if ? 4 : (size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4);
        wr  = we && !is_if;
        exp = exp_rd(addr, n);
        if (is_if) begin
            if_addr_i = addr; if_req_i = 1'b1;
        end else begin
            mem_we_i = we; mem_size_i = size; mem_addr_i = addr;
            mem_wdata_i = wdata; mem_req_i = 1'b1;
        end
        cyc = 0; nw = 0; stray = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                if_addr_i = $urandom; mem_addr_i = $urandom;
                mem_wdata_i = $urandom; mem_size_i = 2'($urandom_range(0, 3));
            end
            if (ram_wr_o) begin
                sh = wdata >> (8 * nw);
                chk("wr_addr", ram_addr_o, addr + 32'(nw));
                chk("wr_data", 32'(ram_dout_o), 32'(sh[7:0]));
                nw++;
            end
            if (is_if ? mem_done_o : if_done_o) stray++;
            done = is_if ? if_done_o : mem_done_o;
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        chk(is_if ? "if_latency" : "mem_latency", 32'(cyc), 32'(wr ? n + 1 : n + 2));
        chk("wr_count", 32'(nw), 32'(wr ? n : 0));
        chk("stray_done", 32'(stray), 32'd0);
        if (is_if) chk("if_data", if_data_o, exp);
        else if (!we) chk("mem_rdata", mem_rdata_o, exp);
        if (wr) for (int i = 0; i < n; i++) begin
            sh = wdata >> (8 * i);
            mdl[addr + 32'(i)] = sh[7:0];
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 32'({if_done_o, mem_done_o}), 32'd0);
    endtask

    // Fetch aborted by a flush sampled at the k-th edge after grant.
    task automatic flush_test(input int k, input logic [31:0] addr);
        int dn = 0;
        if_addr_i = addr; if_req_i = 1'b1;
        repeat (k) begin
            @(posedge clk); #1;
            if (if_done_o) dn++;
        end
        if_flush_i = 1'b1;
        @(posedge clk); #1;
        if (if_done_o) dn++;
        if_flush_i = 1'b0; if_req_i = 1'b0;
        @(posedge clk); #1;
        if (if_done_o) dn++;
        chk("flush_no_done", 32'(dn), 32'd0);
    endtask

    task automatic both_test();
        int cyc, stray;
        logic [31:0] exp_i;
        exp_i = exp_rd(32'h0, 4);
        if_addr_i = 32'h0; if_req_i = 1'b1;
        mem_we_i = 1'b0; mem_size_i = 2'd2; mem_addr_i = 32'h200; mem_req_i = 1'b1;
        cyc = 0; stray = 0;
        while (!mem_done_o && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (if_done_o) stray++;
        end
        mem_req_i = 1'b0;
        chk("both_mem_latency", 32'(cyc), 32'd6);
        chk("both_mem_data", mem_rdata_o, 32'hDEADBEEF);
        cyc = 0;
        while (!if_done_o && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (mem_done_o) stray++;
        end
        if_req_i = 1'b0;
        chk("both_if_latency", 32'(cyc), 32'd6);
        chk("both_if_data", if_data_o, exp_i);
        chk("both_stray", 32'(stray), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_store();
        mem_we_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h180;
        mem_wdata_i = 32'hA1B2C3D4; mem_req_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_wr", 32'(ram_wr_o), 32'd1);
        chk("rst_pre_addr", ram_addr_o, 32'h181);
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_drop", 32'(ram_wr_o), 32'd0);
        chk("rst_no_done", 32'(mem_done_o), 32'd0);
        chk("rst_addr", ram_addr_o, 32'd0);
        mem_req_i = 1'b0;
        #1 rst = 1'b0;
        mdl[32'h180] = 8'hD4;
    endtask

    initial begin
        logic [31:0] a;
        #1 rst = 1'b1;
        #10;
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_if_done", 32'(if_done_o), 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        chk("rst_mem_done", 32'(mem_done_o), 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr_o), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        preload(32'h10, 32'h00100513, 4);
        preload(32'h200, 32'hDEADBEEF, 4);
        preload(32'h80, 32'h000000F0, 1);

        xact(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("fetch_0x10", if_data_o, 32'h00100513);
        both_test();
        xact(1'b0, 1'b1, 2'd1, 32'h100, 32'h1234ABCD);
        xact(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        chk("store_half_word", mem_rdata_o[15:0], 32'h0000ABCD);
        xact(1'b0, 1'b0, 2'd0, 32'h102, 32'h0);
        chk("untouched_0x102", mem_rdata_o, 32'(dflt(32'h102)));
        xact(1'b0, 1'b0, 2'd0, 32'h80, 32'h0);
        chk("byte_load_zext", mem_rdata_o, 32'h000000F0);
        flush_test(4, 32'h20);
        xact(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
        flush_test(5, 32'h44);
        xact(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
        reset_mid_store();
        xact(1'b0, 1'b0, 2'd2, 32'h180, 32'h0);
        xact(1'b0, 1'b1, 2'd2, 32'h180, 32'hA1B2C3D4);
        xact(1'b0, 1'b0, 2'd3, 32'h180, 32'h0);
        chk("restore_word", mem_rdata_o, 32'hA1B2C3D4);
        xact(1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h00005A3C);
        xact(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);

        for (int it = 0; it < 60; it++) begin
            a = 32'h300 + 32'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: xact(1'b1, 1'b0, 2'd2, a, 32'h0);
                1: xact(1'b0, 1'b0, 2'($urandom_range(0, 3)), a, 32'h0);
                2: xact(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, $urandom);
                default: begin
                    flush_test($urandom_range(1, 5), a);
                    xact(1'b1, 1'b0, 2'd2, a + 32'd4, 32'h0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
